// File: rtl/hci_ecc_reg_responder_pkg.sv
// HCI ECC control-port types, register offsets and FSM encoding shared by the ECC
// register responder and its counters.
package hci_package;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        valid;
  } hci_ecc_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } hci_ecc_rsp_t;

  localparam logic [31:0] HCI_ECC_REG_DATA_CORR_CNT   = 32'h00;
  localparam logic [31:0] HCI_ECC_REG_DATA_UNCORR_CNT = 32'h04;
  localparam logic [31:0] HCI_ECC_REG_META_CORR_CNT   = 32'h08;
  localparam logic [31:0] HCI_ECC_REG_META_UNCORR_CNT = 32'h0C;
  localparam logic [31:0] HCI_ECC_REG_SCRUB_INTERVAL  = 32'h10;
  localparam logic [31:0] HCI_ECC_REG_CTRL            = 32'h14;
  localparam logic [31:0] HCI_ECC_REG_WINDOW          = 32'h18;

  typedef enum logic {
    ECC_REG_IDLE,
    ECC_REG_RESP
  } hci_ecc_reg_state_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] hci_ecc_strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/hci_ecc_sat_counter.sv
// Saturating event counter with a write port; a write overrides a same-cycle event.
module hci_ecc_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_i) begin
      cnt_d = wdata_i;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hci_ecc_reg_responder.sv
// Register responder for the HCI ECC control port: error counters, scrubber
// configuration and the scrub-request timer.
module hci_ecc_reg_responder
  import hci_package::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  hci_ecc_req_t req_i,
  output hci_ecc_rsp_t rsp_o,
  input  logic         data_corr_err_i,
  input  logic         data_uncorr_err_i,
  input  logic         meta_corr_err_i,
  input  logic         meta_uncorr_err_i,
  output logic         scrub_req_o,
  input  logic         scrub_gnt_i,
  output logic         scrub_en_o
);

  hci_ecc_reg_state_t state_q, state_d;

  logic [31:0] offset;
  logic        addr_ok;
  logic [2:0]  reg_idx;
  logic        accept;
  logic        wr_en;
  logic [31:0] wmask;
  logic [31:0] rd_mux;

  logic [31:0] interval_q, interval_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] timer_q, timer_d;
  logic        scrub_req_q, scrub_req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [3:0]       evt;
  logic [CNT_W-1:0] cnt     [4];
  logic [31:0]      cnt_ext [4];

  logic unused_wstrb;
  assign unused_wstrb = ^req_i.wstrb[7:4];

  // Offset wraps for addresses below BASE_ADDR, which then fail the window check.
  assign offset  = req_i.addr - BASE_ADDR;
  assign addr_ok = (offset < HCI_ECC_REG_WINDOW) && (offset[1:0] == 2'b00);
  assign reg_idx = offset[4:2];
  assign accept  = (state_q == ECC_REG_IDLE) && req_i.valid;
  assign wmask   = hci_ecc_strb_mask(req_i.wstrb[3:0]);
  assign wr_en   = accept && req_i.write && addr_ok && (req_i.wstrb[3:0] != 4'b0000);

  assign evt = {meta_uncorr_err_i, meta_corr_err_i, data_uncorr_err_i, data_corr_err_i};

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [31:0] cnt_wval;
    logic        unused_wval;
    assign cnt_ext[i] = 32'(cnt[i]);
    assign cnt_wval   = (cnt_ext[i] & ~wmask) | (req_i.wdata & wmask);
    assign unused_wval = ^cnt_wval;

    hci_ecc_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (evt[i]),
      .we_i    (wr_en && (reg_idx == 3'(i))),
      .wdata_i (cnt_wval[CNT_W-1:0]),
      .cnt_o   (cnt[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    unique case (reg_idx)
      3'd0:    rd_mux = cnt_ext[0];
      3'd1:    rd_mux = cnt_ext[1];
      3'd2:    rd_mux = cnt_ext[2];
      3'd3:    rd_mux = cnt_ext[3];
      3'd4:    rd_mux = interval_q;
      3'd5:    rd_mux = {31'b0, ctrl_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    interval_d = interval_q;
    ctrl_d     = ctrl_q;
    unique case (state_q)
      ECC_REG_IDLE: begin
        if (accept) begin
          state_d = ECC_REG_RESP;
          rdata_d = (addr_ok && !req_i.write) ? rd_mux : '0;
          error_d = !addr_ok;
        end
      end
      ECC_REG_RESP: state_d = ECC_REG_IDLE;
      default:      state_d = ECC_REG_IDLE;
    endcase
    if (wr_en && (reg_idx == 3'd4)) begin
      interval_d = (interval_q & ~wmask) | (req_i.wdata & wmask);
    end
    if (wr_en && (reg_idx == 3'd5) && req_i.wstrb[0]) begin
      ctrl_d = req_i.wdata[0];
    end
  end

  // Any reconfiguration restarts the interval and withdraws a pending request.
  always_comb begin
    timer_d     = timer_q;
    scrub_req_d = scrub_req_q;
    if ((wr_en && (reg_idx == 3'd4)) || (ctrl_d == 1'b0) || !ctrl_q ||
        (interval_q == 32'd0)) begin
      timer_d     = '0;
      scrub_req_d = 1'b0;
    end else if (scrub_req_q) begin
      if (scrub_gnt_i) begin
        timer_d     = '0;
        scrub_req_d = 1'b0;
      end
    end else if (timer_q == interval_q - 32'd1) begin
      scrub_req_d = 1'b1;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ECC_REG_IDLE;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      interval_q  <= '0;
      ctrl_q      <= 1'b0;
      timer_q     <= '0;
      scrub_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      interval_q  <= interval_d;
      ctrl_q      <= ctrl_d;
      timer_q     <= timer_d;
      scrub_req_q <= scrub_req_d;
    end
  end

  assign rsp_o.rdata = rdata_q;
  assign rsp_o.error = error_q;
  assign rsp_o.ready = (state_q == ECC_REG_RESP);
  assign scrub_req_o = scrub_req_q;
  assign scrub_en_o  = ctrl_q;

endmodule

// File: tb/tb_hci_ecc_reg_responder.sv
// Randomized bench for the ECC register responder against a register-map model.
module tb_hci_ecc_reg_responder;
  import hci_package::*;

  localparam logic [31:0] Base  = 32'h0000_4000;
  localparam int unsigned CntW  = 4;
  localparam int unsigned CntMax = 15;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  hci_ecc_req_t req_i;
  hci_ecc_rsp_t rsp_o;
  logic         data_corr_err_i = 1'b0;
  logic         data_uncorr_err_i = 1'b0;
  logic         meta_corr_err_i = 1'b0;
  logic         meta_uncorr_err_i = 1'b0;
  logic         scrub_req_o;
  logic         scrub_gnt_i = 1'b0;
  logic         scrub_en_o;

  hci_ecc_reg_responder #(
    .BASE_ADDR (Base),
    .CNT_W     (CntW)
  ) u_dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_i             (req_i),
    .rsp_o             (rsp_o),
    .data_corr_err_i   (data_corr_err_i),
    .data_uncorr_err_i (data_uncorr_err_i),
    .meta_corr_err_i   (meta_corr_err_i),
    .meta_uncorr_err_i (meta_uncorr_err_i),
    .scrub_req_o       (scrub_req_o),
    .scrub_gnt_i       (scrub_gnt_i),
    .scrub_en_o        (scrub_en_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  int unsigned m_cnt [4];
  logic [31:0] m_interval;
  logic        m_ctrl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] off);
    case (off)
      32'h00:  return 32'(m_cnt[0]);
      32'h04:  return 32'(m_cnt[1]);
      32'h08:  return 32'(m_cnt[2]);
      32'h0C:  return 32'(m_cnt[3]);
      32'h10:  return m_interval;
      32'h14:  return {31'b0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] off, input logic [31:0] wd, input logic [7:0] strb);
    logic [31:0] mask;
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{strb[i]}};
    merged = (m_read(off) & ~mask) | (wd & mask);
    if (off < 32'h10) m_cnt[off[3:2]] = merged & CntMax;
    else if (off == 32'h10) m_interval = merged;
    else m_ctrl = merged[0];
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_interval = '0;
    m_ctrl = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One complete access; checks handshake timing, and read data / error against the model.
  task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [7:0] strb, output logic [31:0] rd);
    logic [31:0] off;
    bit ok;
    logic [31:0] exp_rd;
    off = addr - Base;
    ok = (off < 32'h18) && (off[1:0] == 2'b00);
    exp_rd = ok ? m_read(off) : 32'h0;
    req_i.addr = addr; req_i.write = wr; req_i.wdata = wd; req_i.wstrb = strb;
    req_i.valid = 1'b1;
    step();
    chk("ready_hi", 32'(rsp_o.ready), 32'd1);
    rd = rsp_o.rdata;
    if (!wr) chk("rdata", rsp_o.rdata, exp_rd);
    chk("error", 32'(rsp_o.error), 32'(!ok));
    req_i.valid = 1'b0;
    step();
    chk("ready_lo", 32'(rsp_o.ready), 32'd0);
    if (ok && wr && strb[3:0] != 4'b0) m_write(off, wd, strb);
  endtask

  task automatic pulse(input logic [3:0] ev);
    {meta_uncorr_err_i, meta_corr_err_i, data_uncorr_err_i, data_corr_err_i} = ev;
    step();
    {meta_uncorr_err_i, meta_corr_err_i, data_uncorr_err_i, data_corr_err_i} = 4'b0;
    for (int i = 0; i < 4; i++) if (ev[i] && m_cnt[i] < CntMax) m_cnt[i]++;
  endtask

  task automatic read_all();
    logic [31:0] rd;
    for (int i = 0; i < 6; i++) xact(1'b0, Base + 32'(i * 4), 32'h0, 8'h0, rd);
  endtask

  initial begin
    logic [31:0] rd;
    int nready;
    req_i = '0;
    m_reset();
    step(); step();
    chk("rst_ready", 32'(rsp_o.ready), 32'd0);
    chk("rst_rdata", rsp_o.rdata, 32'h0);
    chk("rst_error", 32'(rsp_o.error), 32'd0);
    chk("rst_scrub_req", 32'(scrub_req_o), 32'd0);
    chk("rst_scrub_en", 32'(scrub_en_o), 32'd0);
    rst_ni = 1'b1;
    step();

    read_all();

    xact(1'b1, Base + 32'h10, 32'h0, 8'h0F, rd);
    xact(1'b1, Base + 32'h10, 32'hDEADBEEF, 8'hA5, rd);
    xact(1'b0, Base + 32'h10, 32'h0, 8'h0, rd);
    chk("wstrb_merge", rd, 32'h00AD00EF);

    xact(1'b1, Base, 32'h0, 8'h0F, rd);
    for (int i = 0; i < 20; i++) pulse(4'b0001);
    xact(1'b0, Base, 32'h0, 8'h0, rd);
    chk("saturate", rd, 32'd15);

    // Write and event in the same cycle: the write value must survive.
    req_i.addr = Base; req_i.write = 1'b1; req_i.wdata = 32'd3; req_i.wstrb = 8'h0F;
    req_i.valid = 1'b1;
    data_corr_err_i = 1'b1;
    step();
    data_corr_err_i = 1'b0;
    chk("conflict_ready", 32'(rsp_o.ready), 32'd1);
    req_i.valid = 1'b0;
    step();
    m_cnt[0] = 3;
    xact(1'b0, Base, 32'h0, 8'h0, rd);
    chk("write_wins", rd, 32'd3);

    xact(1'b0, Base + 32'h18, 32'h0, 8'h0, rd);
    xact(1'b0, Base + 32'h02, 32'h0, 8'h0, rd);
    xact(1'b0, Base - 32'h4, 32'h0, 8'h0, rd);
    xact(1'b1, Base + 32'h1C, 32'hFFFFFFFF, 8'hFF, rd);
    read_all();

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        pulse(4'($urandom));
      end else begin
        logic [31:0] a;
        a = Base + 32'($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        xact(1'($urandom), a, $urandom, 8'($urandom), rd);
      end
    end
    read_all();

    // Scrub timer.
    xact(1'b1, Base + 32'h14, 32'h0, 8'h0F, rd);
    xact(1'b1, Base + 32'h10, 32'd5, 8'h0F, rd);
    req_i.addr = Base + 32'h14; req_i.write = 1'b1; req_i.wdata = 32'd1; req_i.wstrb = 8'h0F;
    req_i.valid = 1'b1;
    step();
    chk("ctrl_ready", 32'(rsp_o.ready), 32'd1);
    chk("scrub_en", 32'(scrub_en_o), 32'd1);
    req_i.valid = 1'b0;
    m_ctrl = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("scrub_rise", 32'(scrub_req_o), 32'(k == 5));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("scrub_hold", 32'(scrub_req_o), 32'd1);
    end
    scrub_gnt_i = 1'b1;
    step();
    scrub_gnt_i = 1'b0;
    chk("scrub_drop", 32'(scrub_req_o), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("scrub_again", 32'(scrub_req_o), 32'(k == 5));
    end
    xact(1'b1, Base + 32'h14, 32'h0, 8'h0F, rd);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("scrub_off", 32'(scrub_req_o), 32'd0);
    end

    // Valid held high for six cycles yields three responses.
    nready = 0;
    req_i.addr = Base + 32'h10; req_i.write = 1'b0; req_i.valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("b2b_phase", 32'(rsp_o.ready), 32'(k % 2 == 0));
      nready += int'(rsp_o.ready);
    end
    req_i.valid = 1'b0;
    step();
    chk("b2b_count", 32'(nready), 32'd3);

    // Reset while a response is presented.
    pulse(4'hF);
    req_i.addr = Base; req_i.write = 1'b0; req_i.valid = 1'b1;
    step();
    chk("pre_rst_ready", 32'(rsp_o.ready), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_ready_drop", 32'(rsp_o.ready), 32'd0);
    req_i.valid = 1'b0;
    m_reset();
    step(); step();
    rst_ni = 1'b1;
    step();
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
